// File: rtl/m_lsu_pkg.sv
// Shared types and constants for the M-stage load/store unit.
// Holds the size codes, FSM states, CP0 exception codes and latched request bundle.
package m_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Fields needed after accept to steer and extend the load data
    typedef struct packed {
        logic       we;
        logic       sgn;
        logic [1:0] size;
        logic [1:0] lo;
    } lsu_req_t;

endpackage

// File: rtl/m_lsu_lane.sv
// Byte-lane steering: enables, store replication, alignment check, load extension.
// Purely combinational; request side and load side are independent.
module m_lsu_lane
    import m_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_signed,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_ext
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        unique case (size)
            SIZE_B: begin
                be        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be        = lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = lo[0];
            end
            SIZE_W: begin
                be       = 4'b1111;
                misalign = |lo;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    always_comb begin
        ld_b   = ld_data[{ld_lo, 3'b000} +: 8];
        ld_h   = ld_lo[1] ? ld_data[31:16] : ld_data[15:0];
        ld_ext = ld_data;
        unique case (ld_size)
            SIZE_B:  ld_ext = {{24{ld_signed & ld_b[7]}}, ld_b};
            SIZE_H:  ld_ext = {{16{ld_signed & ld_h[15]}}, ld_h};
            default: ld_ext = ld_data;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: request FSM, bus handshake with timeout,
// address/bus-error exceptions and flush-kill of the in-flight access.
module m_lsu
    import m_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              exc_valid,
    output logic [4:0]        exc_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYC - 1);

    state_e     state, state_n;
    logic [7:0] cnt;
    logic       kill;
    lsu_req_t   lat;

    logic       accept;
    logic       timeout;
    logic       drop;
    logic [3:0] be_c;
    logic [31:0] wd_c;
    logic       mis_c;
    logic [31:0] ld_c;

    m_lsu_lane u_lane (
        .size      (req_size),
        .lo        (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (be_c),
        .wdata_rep (wd_c),
        .misalign  (mis_c),
        .ld_size   (lat.size),
        .ld_lo     (lat.lo),
        .ld_signed (lat.sgn),
        .ld_data   (bus_rdata),
        .ld_ext    (ld_c)
    );

    assign req_ready = (state == IDLE);
    assign bus_req   = (state == ACCESS);
    // A flush in the completing cycle still kills the response
    assign drop      = kill | flush;

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = req_valid;
            ACCESS:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_n = mis_c ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    state_n = RESP;
                end else if (cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            kill      <= 1'b0;
            lat       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            unique case (state)
                IDLE: begin
                    kill <= 1'b0;
                    cnt  <= '0;
                    if (accept && mis_c) begin
                        rsp_valid <= 1'b1;
                        exc_valid <= 1'b1;
                        exc_code  <= req_we ? EXC_ADES : EXC_ADEL;
                    end else if (accept) begin
                        lat.we    <= req_we;
                        lat.sgn   <= req_signed;
                        lat.size  <= req_size;
                        lat.lo    <= req_addr[1:0];
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= be_c;
                        bus_wdata <= wd_c;
                    end
                end
                ACCESS: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (bus_ack) begin
                        rsp_valid <= !drop;
                        if (!drop && !lat.we) begin
                            rsp_rdata <= ld_c;
                        end
                    end else if (timeout) begin
                        rsp_valid <= !drop;
                        exc_valid <= !drop;
                        if (!drop) begin
                            exc_code <= EXC_DBE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    kill <= 1'b0;
                end
                default: begin
                    kill <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_lsu.sv
// Directed plus randomized bench for m_lsu against an arithmetic reference model.
// Bus acks, flushes and timeouts are scheduled per transaction.
module tb_m_lsu;
    import m_lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        flush, stall;
    logic        rsp_valid, exc_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  exc_code;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    m_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 32'(1 << (a % 4));
        if (sz == 2'd1) return ((a / 2) % 2 == 1) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        if (sz == 2'd2) return d;
        if (sz == 2'd0) begin
            v = (d >> ((a % 4) * 8)) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else begin
            v = (d >> (((a / 2) % 2) * 16)) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from accept to the cycle after its response.
    // ack_at/flush_at are ACCESS-cycle indices; out of range means never.
    task automatic xact(input string tag, input logic we, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at, input int flush_at);
        bit mis, killed, tmo, done;
        int stalls, reqs, ncyc;
        logic [31:0] exp_rd;
        logic [4:0]  code;
        mis = m_mis(sz, a);
        killed = 0; tmo = 0; stalls = 0; reqs = 0; ncyc = 0;
        req_valid = 1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd; flush = 0; bus_ack = 0;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 1);
        chk({tag, ".stall0"}, 32'(stall), 1);
        tick();
        req_valid = 0;
        req_addr = $urandom;
        req_wdata = $urandom;
        if (!mis) begin
            for (int i = 0; i < TO; i++) begin
                bus_ack = (i == ack_at);
                bus_rdata = (i == ack_at) ? rd : $urandom;
                flush = (i == flush_at);
                if (i == flush_at) killed = 1;
                #1;
                stalls += int'(stall);
                reqs += int'(bus_req);
                ncyc++;
                chk({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
                chk({tag, ".be"}, 32'(bus_be), m_be(sz, a));
                chk({tag, ".we"}, 32'(bus_we), 32'(we));
                if (we) chk({tag, ".wdata"}, bus_wdata, m_wd(sz, wd));
                done = (i == ack_at) || (i == TO - 1);
                tmo = (i != ack_at) && (i == TO - 1);
                tick();
                if (done) break;
            end
            bus_ack = 0;
            flush = 0;
            chk({tag, ".stalls"}, 32'(stalls), 32'(ncyc));
            chk({tag, ".reqs"}, 32'(reqs), 32'(ncyc));
        end else begin
            chk({tag, ".nobus"}, 32'(bus_req), 0);
        end
        code = mis ? (we ? 5'd5 : 5'd4) : (tmo ? 5'd7 : 5'd0);
        exp_rd = (!we && !mis && !tmo) ? m_load(sz, sgn, a, rd) : 32'd0;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(!killed));
        chk({tag, ".exc_valid"}, 32'(exc_valid), 32'((mis || tmo) && !killed));
        if (!killed) chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        if ((mis || tmo) && !killed) chk({tag, ".code"}, 32'(exc_code), 32'(code));
        chk({tag, ".stall_r"}, 32'(stall), 0);
        chk({tag, ".busreq_r"}, 32'(bus_req), 0);
        chk({tag, ".ready_r"}, 32'(req_ready), 0);
        tick();
        chk({tag, ".strobe"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
        #12;
        chk("rst.ready", 32'(req_ready), 1);
        chk("rst.stall", 32'(stall), 0);
        chk("rst.busreq", 32'(bus_req), 0);
        chk("rst.rsp", 32'(rsp_valid), 0);
        chk("rst.exc", 32'(exc_valid), 0);
        chk("rst.be", 32'(bus_be), 0);
        chk("rst.addr", bus_addr, 0);
        tick();
        reset = 0;
        tick();

        xact("lb", 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80FF_0102, 0, 99);
        xact("sh", 1, 2'd1, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 99);
        xact("lw_mis", 0, 2'd2, 0, 32'h3001, 32'h0, 32'h0, 0, 99);
        xact("sw_mis", 1, 2'd2, 0, 32'h3002, 32'h1234, 32'h0, 0, 99);
        xact("rsv", 0, 2'd3, 0, 32'h4000, 32'h0, 32'h0, 0, 99);
        xact("lw_tmo", 0, 2'd2, 0, 32'h5000, 32'h0, 32'h0, 99, 99);
        xact("sw_flush", 1, 2'd2, 0, 32'h6000, 32'hCAFE_F00D, 32'h0, 2, 0);
        xact("lhu", 0, 2'd1, 0, 32'h7002, 32'h0, 32'h9876_5432, 1, 99);

        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h8000; flush = 1;
        tick();
        req_valid = 0; flush = 0;
        #1;
        chk("iflush.busreq", 32'(bus_req), 0);
        chk("iflush.ready", 32'(req_ready), 1);
        tick();
        chk("iflush.rsp", 32'(rsp_valid), 0);

        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h9000;
        tick();
        req_valid = 0;
        #1;
        chk("mrst.busreq0", 32'(bus_req), 1);
        reset = 1;
        #1;
        chk("mrst.busreq1", 32'(bus_req), 0);
        chk("mrst.stall", 32'(stall), 0);
        chk("mrst.ready", 32'(req_ready), 1);
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            bus_ack = 1;
            #1;
            chk("mrst.norsp", 32'(rsp_valid | exc_valid), 0);
            tick();
        end
        bus_ack = 0;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int fa;
            a = $urandom;
            fa = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 99;
            xact("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a,
                 $urandom, $urandom, int'($urandom_range(5)), fa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_lsu.md
Name: m_lsu

Overview:
- M-stage load/store unit for the pipelined MIPS core.
- Accepts one memory request per instruction from the M stage and runs a variable-latency handshake with the external data memory/bus.
- Generates byte enables and replicated store data; extends load data by size and sign.
- Reports address exceptions (AdEL/AdES) and bus timeouts (DBE) to CP0, stalling the pipeline while the access is outstanding.

Parameters:
- ADDR_W, 32, address width, minimum 3.
- TIMEOUT_CYC, 15, number of ACCESS cycles without bus_ack before a DBE is raised, range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  M-stage instruction is a load/store; held until accepted.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load (byte/half only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- flush  in  1  exception/eret kill of the in-flight instruction.
- stall  out  1  freeze F..M stages.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data, 0 for stores.
- exc_valid  out  1  exception strobe, coincident with the response cycle.
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  ADDR_W  word-aligned address; low 2 bits = 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  store data.
- bus_ack  in  1  bus acknowledge.
- bus_rdata  in  32  bus read data.

Behaviour:
- Reset (asynchronous): state=IDLE, timeout counter=0, kill=0. All registered outputs are 0; req_ready=1; stall=0.
- IDLE:
  - req_ready=1; stall=req_valid.
  - Accept when req_valid & ~flush.
  - Misaligned or reserved-size requests go to RESP with no bus cycle:
    - half with addr[0]=1 → exception.
    - word with addr[1:0]≠0 → exception.
    - size 11 → exception.
    - exc_code = AdES if req_we, else AdEL.
  - All other accepted requests latch the bus fields and go to ACCESS.
- ACCESS:
  - stall=1; bus_req=1.
  - bus_addr, bus_we, bus_be and bus_wdata stay stable until bus_ack or timeout.
  - bus_ack may arrive in the first ACCESS cycle. On ack, a load captures bus_rdata and the state goes to RESP.
  - The counter increments each cycle without ack. At TIMEOUT_CYC, bus_req drops and the state goes to RESP with DBE.
- RESP:
  - Lasts one cycle; stall=0; rsp_valid=1 unless kill.
  - exc_valid=1 for an exception unless kill; rsp_rdata and exc_code are registered.
  - Next state is IDLE. No new request is accepted in this cycle.
- Minimum latency: accept at cycle 0, ack at cycle 1, rsp_valid at cycle 2.
- Byte enables:
  - byte → 1<<addr[1:0].
  - half → 0011 if addr[1]=0, else 1100.
  - word → 1111.
- Store data: byte replicated ×4, half replicated ×2, word passed through.
- Load extension:
  - Byte lane addr[1:0] or half lane addr[1] is selected from the captured data.
  - Sign- or zero-extended per req_signed.
  - Word ignores req_signed.
- flush:
  - In IDLE: the request is not accepted.
  - In ACCESS: sets kill. The bus transaction still completes (ack or timeout), preserving protocol; RESP then emits no rsp_valid/exc_valid.
  - In RESP: ignored; the response is already committed.
- Reset mid-ACCESS: bus_req drops immediately and the state returns to IDLE; no response is produced.

Decomposition:
- Package m_lsu_pkg:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_RSV.
  - State encoding IDLE/ACCESS/RESP.
  - EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
- Sub-module m_lsu_lane: purely combinational; produces byte enables, store replication, misalign detection and load extension. The FSM and counter stay in m_lsu.

Test Plan:
- Load byte signed, addr=0x1003, bus_rdata=0x80FF_0102, ack on first ACCESS cycle → rsp_valid at cycle 2, rsp_rdata=0xFFFF_FF80, bus_be=1000, bus_addr=0x1000.
- Store half, addr=0x2002, wdata=0x0000_BEEF, ack after 3 wait cycles → bus_be=1100, bus_wdata=0xBEEF_BEEF; stall high for 4 cycles; rsp_valid once.
- Load word, addr=0x3001 → no bus_req; next cycle exc_valid=1, exc_code=4.
- Store word, addr=0x3002 → no bus_req; exc_code=5.
- Load with no ack, TIMEOUT_CYC=4 → bus_req high exactly 4 cycles, then exc_code=7, stall released.
- flush during ACCESS of a store, ack 2 cycles later → write completes with bus_be=1111; RESP has rsp_valid=0 and exc_valid=0.
- reset asserted mid-ACCESS → bus_req=0 the same cycle; no response produced.
